// File: rtl/my_keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: row drive patterns, status-word layout,
// frame-result and row-state encodings.
package my_keypad_scanner_pkg;

  localparam int KEY_W     = 4;
  localparam int KEY_LSB   = 0;
  localparam int VALID_BIT = 8;
  localparam int OVF_BIT   = 9;

  localparam logic [3:0] ROW_PAT0 = 4'b1110;
  localparam logic [3:0] ROW_PAT1 = 4'b1101;
  localparam logic [3:0] ROW_PAT2 = 4'b1011;
  localparam logic [3:0] ROW_PAT3 = 4'b0111;

  typedef enum logic [1:0] {NONE = 2'd0, KEY = 2'd1, MULTI = 2'd2} frame_res_e;

  typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} row_state_e;

  function automatic logic [3:0] row_pattern(input row_state_e row);
    case (row)
      ROW0:    return ROW_PAT0;
      ROW1:    return ROW_PAT1;
      ROW2:    return ROW_PAT2;
      ROW3:    return ROW_PAT3;
      default: return ROW_PAT0;
    endcase
  endfunction

  // Accumulated hit count is saturated at 2, so 2 already means "two or more".
  function automatic frame_res_e classify(input logic [1:0] hits);
    case (hits)
      2'd0:    return NONE;
      2'd1:    return KEY;
      default: return MULTI;
    endcase
  endfunction

endpackage

// File: rtl/my_keypad_debounce.sv
// Frame-level debounce and re-arm logic: a press event needs DEB_FRAMES identical KEY
// frames while armed; only a stable all-released period re-arms.
module my_keypad_debounce
  import my_keypad_scanner_pkg::*;
#(
  parameter int DEB_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_vld,
  input  frame_res_e       i_frame_res,
  input  logic [KEY_W-1:0] i_frame_code,
  output logic             o_evt,
  output logic [KEY_W-1:0] o_evt_code
);

  localparam int DCNT_W = $clog2(DEB_FRAMES + 1);
  localparam logic [DCNT_W-1:0] DEB_MAX = DCNT_W'(DEB_FRAMES);

  frame_res_e        r_prev_res;
  logic [KEY_W-1:0]  r_prev_code;
  logic [DCNT_W-1:0] r_stab;
  logic              r_armed;

  logic              w_same;
  logic [DCNT_W-1:0] w_stab_nxt;

  // Codes only distinguish KEY frames; NONE and MULTI frames match on type alone.
  always_comb begin
    w_same = (i_frame_res == r_prev_res) &&
             ((i_frame_res != KEY) || (i_frame_code == r_prev_code));
    if (!w_same)
      w_stab_nxt = DCNT_W'(1);
    else if (r_stab == DEB_MAX)
      w_stab_nxt = r_stab;
    else
      w_stab_nxt = r_stab + DCNT_W'(1);
  end

  assign o_evt      = i_frame_vld && (i_frame_res == KEY) && (w_stab_nxt == DEB_MAX) && r_armed;
  assign o_evt_code = i_frame_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_res  <= NONE;
      r_prev_code <= '0;
      r_stab      <= '0;
      r_armed     <= 1'b1;
    end else if (i_frame_vld) begin
      r_prev_res  <= i_frame_res;
      r_prev_code <= i_frame_code;
      r_stab      <= w_stab_nxt;
      if ((i_frame_res == NONE) && (w_stab_nxt == DEB_MAX))
        r_armed <= 1'b1;
      else if (o_evt)
        r_armed <= 1'b0;
    end
  end

endmodule

// File: rtl/my_keypad_scanner.sv
// 4x4 keypad scanner: row rotation, frame classification and CPU status word.
// Defining KEYPAD_IRQ_EN adds an irq output that mirrors the valid flag.
//
// state | meaning
// ROW0  | driving row 0 low (row_out=1110)
// ROW1  | driving row 1 low (row_out=1101)
// ROW2  | driving row 2 low (row_out=1011)
// ROW3  | driving row 3 low (row_out=0111); its sample closes the frame
module my_keypad_scanner
  import my_keypad_scanner_pkg::*;
#(
  parameter int SCAN_MAX   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  input  logic        re,
  output logic [31:0] rdata
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CNT_W = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;
  row_state_e       r_row, w_row_nxt;
  logic [1:0]       w_row_idx;

  assign w_tc = (r_cnt == CNT_W'(SCAN_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_tc)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_row <= ROW0;
    else
      r_row <= w_row_nxt;
  end

  always_comb begin
    w_row_nxt = r_row;
    if (w_tc) begin
      case (r_row)
        ROW0:    w_row_nxt = ROW1;
        ROW1:    w_row_nxt = ROW2;
        ROW2:    w_row_nxt = ROW3;
        ROW3:    w_row_nxt = ROW0;
        default: w_row_nxt = ROW0;
      endcase
    end
  end

  assign row_out   = row_pattern(r_row);
  assign w_row_idx = r_row;

  logic [3:0]       w_hit;
  logic [2:0]       w_row_hits;
  logic [1:0]       w_row_col;
  logic [1:0]       w_base_hits;
  logic [2:0]       w_sum;
  logic [1:0]       w_acc_hits;
  logic [KEY_W-1:0] w_acc_code;

  logic [1:0]       r_hits;
  logic [KEY_W-1:0] r_code_acc;
  logic             r_fr_vld;
  frame_res_e       r_fr_res;
  logic [KEY_W-1:0] r_fr_code;

  assign w_hit = ~col_in;

  // Row 0 starts a fresh frame; the code is only meaningful when exactly one key is seen.
  always_comb begin
    w_row_hits = '0;
    w_row_col  = '0;
    for (int c = 3; c >= 0; c--) begin
      if (w_hit[c]) begin
        w_row_hits = w_row_hits + 3'd1;
        w_row_col  = 2'(c);
      end
    end
    w_base_hits = (r_row == ROW0) ? 2'd0 : r_hits;
    w_sum       = {1'b0, w_base_hits} + w_row_hits;
    w_acc_hits  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_acc_code  = ((w_base_hits == 2'd0) && (w_row_hits != 3'd0)) ? {w_row_idx, w_row_col}
                                                                 : r_code_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits     <= '0;
      r_code_acc <= '0;
      r_fr_vld   <= 1'b0;
      r_fr_res   <= NONE;
      r_fr_code  <= '0;
    end else begin
      r_fr_vld <= 1'b0;
      if (w_tc) begin
        r_hits     <= w_acc_hits;
        r_code_acc <= w_acc_code;
        if (r_row == ROW3) begin
          r_fr_vld  <= 1'b1;
          r_fr_res  <= classify(w_acc_hits);
          r_fr_code <= w_acc_code;
        end
      end
    end
  end

  logic             w_evt;
  logic [KEY_W-1:0] w_evt_code;

  my_keypad_debounce #(
    .DEB_FRAMES (DEB_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_vld  (r_fr_vld),
    .i_frame_res  (r_fr_res),
    .i_frame_code (r_fr_code),
    .o_evt        (w_evt),
    .o_evt_code   (w_evt_code)
  );

  logic [KEY_W-1:0] r_key;
  logic             r_valid;
  logic             r_ovf;

  // A new event beats a simultaneous read; overflow marks an unread code being replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_evt) begin
      r_key   <= w_evt_code;
      r_valid <= 1'b1;
      r_ovf   <= r_valid & ~re;
    end else if (re) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  always_comb begin
    rdata                       = '0;
    rdata[KEY_LSB +: KEY_W]     = r_key;
    rdata[VALID_BIT]            = r_valid;
    rdata[OVF_BIT]              = r_ovf;
  end

`ifdef KEYPAD_IRQ_EN
  assign irq = r_valid;
`endif

endmodule

// File: doc/my_keypad_scanner.md
MY_KEYPAD_SCANNER -- requirements
Module: my_keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_MAX, default 50000: clock cycles per row dwell minus one.
REQ-002 SHALL have parameter DEB_FRAMES, default 4: number of consecutive identical frame results needed for acceptance.
REQ-003 SHALL have port clk, input, 1 bit: single system clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port row_out, output, 4 bits: one-cold active-low row drive to a 4x4 keypad.
REQ-006 SHALL have port col_in, input, 4 bits: active-low column sense, pulled up externally.
REQ-007 SHALL have port re, input, 1 bit: CPU read-acknowledge strobe.
REQ-008 SHALL have port rdata, output, 32 bits: status word; [3:0] key code, [8] valid, [9] overflow, all other bits 0.

Function
REQ-009 SHALL run a dwell counter 0..SCAN_MAX that wraps to 0 after SCAN_MAX.
REQ-010 SHALL, when the counter equals SCAN_MAX, sample ~col_in for the driven row, then rotate row_out 1110->1101->1011->0111->1110.
REQ-011 SHALL form a frame result after the row-3 sample: exactly one asserted key gives KEY(code = row*4+col); none gives NONE; two or more gives MULTI.
REQ-012 SHALL increment a stable count, saturating at DEB_FRAMES, when a frame result equals the previous one, and otherwise set it to 1.
REQ-013 SHALL keep an armed flag; stable NONE at DEB_FRAMES sets armed=1.
REQ-014 SHALL raise a press event when stable KEY reaches DEB_FRAMES while armed=1; the event latches the code, sets valid, and clears armed.
REQ-015 SHALL produce no event for a held key (no auto-repeat).
REQ-016 SHALL treat MULTI as never producing an event and never setting armed.
REQ-017 SHALL drive rdata combinationally from registers, with zero-cycle read latency.
REQ-018 SHALL clear valid and overflow on the clock edge where re=1.
REQ-019 SHALL, for an event while valid=1 with re=0, overwrite the code and set overflow.
REQ-020 SHALL, for an event and re=1 in the same cycle, let the event win: valid=1, new code, overflow=0.
REQ-021 SHALL have event latency of one cycle after the row-3 sample edge of the accepting frame; a frame lasts 4*(SCAN_MAX+1) cycles.

Reset
REQ-022 SHALL, on rst_n=0, immediately set row_out=4'b1110, counter=0, code=0, valid=0, overflow=0, stable count=0, armed=1, previous result=NONE, and rdata=32'h0.
REQ-023 SHALL discard any partial frame when reset occurs mid-frame; scanning restarts at row 0.

Configuration
REQ-024 SHALL, when macro KEYPAD_IRQ_EN is defined, add output irq (1 bit) equal to valid, asserting on the event edge and deasserting on the re edge.
REQ-025 SHALL, when KEYPAD_IRQ_EN is undefined, have no irq port; all other behaviour is identical.

Structure
REQ-026 SHALL place in a shared package the row-pattern constants, the rdata bit positions (KEY_LSB=0, VALID_BIT=8, OVF_BIT=9), the key-code width (4), and the frame-result enum {NONE, KEY, MULTI}.
REQ-027 SHALL place debounce and arming (REQ-012 to REQ-016) in sub-module my_keypad_debounce; scanning and CPU register logic stay in the top.

Verification (SCAN_MAX=3, DEB_FRAMES=2; frame = 16 cycles)
REQ-028 SHALL check reset: assert rst_n=0 mid-dwell -> row_out=4'b1110 and rdata=32'h0 with no clock edge; after release, first rotation occurs 4 cycles later.
REQ-029 SHALL check a single press: hold row2/col1 for 3 frames -> rdata=32'h0000_0109 one cycle after the 2nd identical frame; further holding produces no new event.
REQ-030 SHALL check read clear: pulse re for one cycle -> next cycle rdata=32'h0000_0009.
REQ-031 SHALL check overflow: key 0 accepted, release 2 frames, then key F accepted with no re -> rdata=32'h0000_030F; re in the same cycle as an event -> rdata=32'h0000_01xx with bit 9 clear.
REQ-032 SHALL check MULTI rejection: hold keys 5 and 6 together for 4 frames -> valid stays 0; release 2 frames, press key 5 -> code 5 accepted.
REQ-033 SHALL check the irq build: with KEYPAD_IRQ_EN, irq tracks valid through scenarios REQ-029 and REQ-030.
